// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC instruction-fetch sequencer.
package fetch_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] NOP_INSTR_DEF = 16'h0800;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_REQ   = 3'd1;
    localparam logic [2:0] ENC_WAIT  = 3'd2;
    localparam logic [2:0] ENC_VALID = 3'd3;
    localparam logic [2:0] ENC_HALT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_REQ   = ENC_REQ,
        ST_WAIT  = ENC_WAIT,
        ST_VALID = ENC_VALID,
        ST_HALT  = ENC_HALT
    } state_t;

endpackage

// File: rtl/fetch_seq_pc_inc2.sv
// Combinational PC + 2 incrementer; wraps modulo 2^16 with no carry out.
module pc_inc2
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] a_i,
    output logic [PC_W-1:0] sum_o
);

    assign sum_o = a_i + PC_W'(2);

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues one memory read at a time, presents the instruction to decode.
// Optional macro FETCH_ALIGN_CHK_EN: odd redirect targets raise a sticky err_o and halt instead of being rounded down.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [PC_W-1:0]  redirect_pc_i,
    input  logic             halt_i,
    output logic             mem_req_o,
    output logic [PC_W-1:0]  mem_addr_o,
    input  logic             mem_stall_i,
    input  logic             mem_done_i,
    input  logic [PC_W-1:0]  mem_data_i,
    output logic [PC_W-1:0]  instr_o,
    output logic [PC_W-1:0]  pc_o,
    output logic [PC_W-1:0]  pc_plus2_o,
    output logic             instr_valid_o,
    output logic             halted_o,
    output logic             err_o
);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_plus2;
    logic [PC_W-1:0] instr_q;
    logic            pending_q;
    logic            err_q;
    logic [PC_W-1:0] redir_pc;
    logic            redir_bad;
    logic            mem_accept;

    pc_inc2 u_pc_inc2 (
        .a_i   (pc_q),
        .sum_o (pc_plus2)
    );

`ifdef FETCH_ALIGN_CHK_EN
    assign redir_pc  = redirect_pc_i;
    assign redir_bad = redirect_i & redirect_pc_i[0];
`else
    assign redir_pc  = redirect_pc_i & ~PC_W'(1);
    assign redir_bad = 1'b0;
`endif

    assign pc_d       = redirect_i ? redir_pc : pc_plus2;
    assign mem_accept = ~mem_stall_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            instr_q   <= NOP_INSTR;
            err_q     <= 1'b0;
        end else if (state_q != ST_HALT && redir_bad) begin
            // Odd target: halt without loading pc; any in-flight response dies in HALT.
            err_q     <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= ST_HALT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    if (redirect_i) pc_q <= pc_d;
                end
                ST_REQ: begin
                    if (redirect_i) begin
                        pc_q <= pc_d;
                        if (mem_accept && !mem_done_i) begin
                            pending_q <= 1'b1;
                            state_q   <= ST_WAIT;
                        end
                    end else if (mem_accept) begin
                        if (mem_done_i) begin
                            instr_q <= mem_data_i;
                            state_q <= ST_VALID;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (redirect_i) begin
                        pc_q <= pc_d;
                        if (mem_done_i) begin
                            pending_q <= 1'b0;
                            state_q   <= ST_REQ;
                        end else begin
                            pending_q <= 1'b1;
                        end
                    end else if (mem_done_i) begin
                        if (pending_q) begin
                            pending_q <= 1'b0;
                            state_q   <= ST_REQ;
                        end else begin
                            instr_q <= mem_data_i;
                            state_q <= ST_VALID;
                        end
                    end
                end
                ST_VALID: begin
                    if (redirect_i) begin
                        pc_q    <= pc_d;
                        state_q <= ST_REQ;
                    end else if (!stall_i) begin
                        if (halt_i) begin
                            state_q <= ST_HALT;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o     = (state_q == ST_REQ);
    assign mem_addr_o    = pc_q;
    assign instr_valid_o = (state_q == ST_VALID);
    assign instr_o       = instr_valid_o ? instr_q : NOP_INSTR;
    assign pc_o          = pc_q;
    assign pc_plus2_o    = pc_plus2;
    assign halted_o      = (state_q == ST_HALT);
    assign err_o         = err_q;

endmodule
